fd_window_loader: RTL and testbench

// - Loads one FAST corner-test window: one reference pixel plus NPTS Bresenham-circle pixels, streamed from SRAM.
// - Holds the window stable for the segment-test comparator, with a programmable threshold register.
// - Parametrised successor of the fixed 16x8-bit detector register bank.
// - Adds a load FSM, valid/ready input handshake, window-valid/consume output handshake and abort/restart.

---
 rtl/fd_pkg.sv | 13 +
 rtl/fd_slot_bank.sv | 51 +++++
 rtl/fd_window_loader.sv | 107 ++++++++++
 tb/tb_fd_window_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// Shared types and constants for the FAST detector window loader and comparator.
package fd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } fd_state_e;

   localparam int unsigned PIX_W_DEFAULT = 8;
   localparam int unsigned THRES_DEFAULT = 30;

endpackage

// File: rtl/fd_slot_bank.sv
// Window slot storage: slot 0 is the reference pixel, slots 1..NPTS are the circle pixels.
module fd_slot_bank
   import fd_pkg::*;
#(
   parameter int unsigned PIX_W = PIX_W_DEFAULT,
   parameter int unsigned NPTS  = 16,
   parameter int unsigned IDX_W = $clog2(NPTS + 1)
) (
   input  logic                   clock,
   input  logic                   nReset,
   input  logic                   we,
   input  logic [IDX_W-1:0]       idx,
   input  logic [PIX_W-1:0]       din,
   output logic [PIX_W-1:0]       ref_slot,
   output logic [NPTS*PIX_W-1:0]  adj_slots
);

   logic [NPTS:0]      wr_sel;
   logic [PIX_W-1:0]   slot_q [NPTS+1];
   logic [PIX_W-1:0]   slot_d [NPTS+1];

   always_comb begin
      wr_sel = '0;
      for (int unsigned k = 0; k <= NPTS; k++) begin
         wr_sel[k] = we && (idx == IDX_W'(k));
         slot_d[k] = wr_sel[k] ? din : slot_q[k];
      end
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         for (int unsigned k = 0; k <= NPTS; k++) begin
            slot_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k <= NPTS; k++) begin
            slot_q[k] <= slot_d[k];
         end
      end
   end

   // Slot 1 lands in the MSBs, slot NPTS in the LSBs.
   always_comb begin
      ref_slot  = slot_q[0];
      adj_slots = '0;
      for (int unsigned k = 1; k <= NPTS; k++) begin
         adj_slots[(NPTS-k)*PIX_W +: PIX_W] = slot_q[k];
      end
   end

endmodule

// File: rtl/fd_window_loader.sv
// Streams one FAST window (reference + NPTS circle pixels) into the slot bank and holds it
// for the segment-test comparator; also owns the programmable threshold register.
module fd_window_loader
   import fd_pkg::*;
#(
   parameter int unsigned PIX_W         = fd_pkg::PIX_W_DEFAULT,
   parameter int unsigned NPTS          = 16,
   parameter int unsigned THRES_W       = 8,
   parameter int unsigned THRES_DEFAULT = fd_pkg::THRES_DEFAULT
) (
   input  logic                   clock,
   input  logic                   nReset,
   input  logic                   start,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [PIX_W-1:0]       in_data,
   output logic                   win_valid,
   input  logic                   consume,
   output logic [PIX_W-1:0]       ref_pixel,
   output logic [NPTS*PIX_W-1:0]  adj_pixel,
   input  logic                   thres_we,
   input  logic [THRES_W-1:0]     thres_in,
   output logic [THRES_W-1:0]     thres
);

   localparam int unsigned IDX_W = $clog2(NPTS + 1);

   fd_state_e            state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [THRES_W-1:0]   thres_q, thres_d;
   logic                 accept;
   logic [PIX_W-1:0]     ref_slot;
   logic [NPTS*PIX_W-1:0] adj_slots;

   // A start in LOAD restarts the window and drops any beat offered in that cycle.
   assign accept = (state_q == LOAD) && in_valid && !start;

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         thres_q <= THRES_W'(THRES_DEFAULT);
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         thres_q <= thres_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      thres_d = thres_we ? thres_in : thres_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               idx_d   = '0;
            end
         end
         LOAD: begin
            if (start) begin
               idx_d = '0;
            end else if (accept) begin
               if (idx_q == IDX_W'(NPTS)) begin
                  state_d = FULL;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         FULL: begin
            if (consume) begin
               state_d = start ? LOAD : IDLE;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_comb begin
      in_ready  = (state_q == LOAD);
      win_valid = (state_q == FULL);
      ref_pixel = win_valid ? ref_slot : '0;
      adj_pixel = win_valid ? adj_slots : '0;
      thres     = thres_q;
   end

   fd_slot_bank #(
      .PIX_W (PIX_W),
      .NPTS  (NPTS),
      .IDX_W (IDX_W)
   ) u_slot_bank (
      .clock     (clock),
      .nReset    (nReset),
      .we        (accept),
      .idx       (idx_q),
      .din       (in_data),
      .ref_slot  (ref_slot),
      .adj_slots (adj_slots)
   );

endmodule

// File: tb/tb_fd_window_loader.sv
// Directed bench for fd_window_loader: a window-level model checked every cycle plus literal pins.
module tb_fd_window_loader;

   localparam int PIX_W = 8;
   localparam int NPTS  = 16;

   logic                  clock;
   logic                  nReset;
   logic                  start;
   logic                  in_valid;
   logic                  in_ready;
   logic [PIX_W-1:0]      in_data;
   logic                  win_valid;
   logic                  consume;
   logic [PIX_W-1:0]      ref_pixel;
   logic [NPTS*PIX_W-1:0] adj_pixel;
   logic                  thres_we;
   logic [7:0]            thres_in;
   logic [7:0]            thres;

   int checks = 0;
   int errors = 0;

   fd_window_loader dut (
      .clock     (clock),
      .nReset    (nReset),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .win_valid (win_valid),
      .consume   (consume),
      .ref_pixel (ref_pixel),
      .adj_pixel (adj_pixel),
      .thres_we  (thres_we),
      .thres_in  (thres_in),
      .thres     (thres)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Model: mode 0 idle, 1 collecting beats, 2 window held.
   int         m_mode;
   int         m_cnt;
   logic [7:0] m_thr;
   logic [7:0] m_win [0:NPTS];

   always @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         m_mode <= 0;
         m_cnt  <= 0;
         m_thr  <= 8'd30;
         for (int k = 0; k <= NPTS; k++) m_win[k] <= 8'h00;
      end else begin
         if (thres_we) m_thr <= thres_in;
         case (m_mode)
            0: if (start) begin
               m_mode <= 1;
               m_cnt  <= 0;
            end
            1: if (start) begin
               m_cnt <= 0;
            end else if (in_valid) begin
               m_win[m_cnt] <= in_data;
               m_cnt        <= m_cnt + 1;
               if (m_cnt == NPTS) m_mode <= 2;
            end
            default: if (consume) begin
               m_mode <= start ? 1 : 0;
               m_cnt  <= 0;
            end
         endcase
      end
   end

   always @(negedge clock) begin
      logic [NPTS*PIX_W-1:0] exp_adj;
      logic [7:0]            exp_ref;
      exp_adj = '0;
      exp_ref = 8'h00;
      if (m_mode == 2) begin
         exp_ref = m_win[0];
         for (int k = 1; k <= NPTS; k++) exp_adj[(NPTS-k)*8 +: 8] = m_win[k];
      end
      check("cyc_in_ready", 128'(in_ready), 128'(m_mode == 1));
      check("cyc_win_valid", 128'(win_valid), 128'(m_mode == 2));
      check("cyc_thres", 128'(thres), 128'(m_thr));
      check("cyc_ref", 128'(ref_pixel), 128'(exp_ref));
      check("cyc_adj", 128'(adj_pixel), 128'(exp_adj));
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic beat(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      logic [NPTS*PIX_W-1:0] held_adj;
      logic [7:0]            held_ref;
      nReset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      consume = 1'b0; thres_we = 1'b0; thres_in = 8'h00;
      tick();
      tick();
      nReset = 1'b1;
      tick();
      check("reset_thres", 128'(thres), 128'd30);
      check("reset_win_valid", 128'(win_valid), 128'd0);
      check("reset_in_ready", 128'(in_ready), 128'd0);
      check("reset_adj", 128'(adj_pixel), 128'd0);
      check("reset_ref", 128'(ref_pixel), 128'd0);

      // consume while idle does nothing
      consume = 1'b1; tick(); consume = 1'b0;
      check("idle_consume_ready", 128'(in_ready), 128'd0);

      // Back-to-back load
      pulse_start();
      check("load_in_ready", 128'(in_ready), 128'd1);
      for (int i = 0; i < NPTS; i++) beat(8'(8'h10 + i));
      check("pre_last_win_valid", 128'(win_valid), 128'd0);
      beat(8'h20);
      check("load1_win_valid", 128'(win_valid), 128'd1);
      check("load1_ref", 128'(ref_pixel), 128'h10);
      check("load1_adj_msb", 128'(adj_pixel[127:120]), 128'h11);
      check("load1_adj_lsb", 128'(adj_pixel[7:0]), 128'h20);
      consume = 1'b1; tick(); consume = 1'b0;
      check("consume_idle", 128'(win_valid), 128'd0);

      // Load with in_valid toggling
      pulse_start();
      for (int i = 0; i <= NPTS; i++) begin
         in_valid = 1'b0; in_data = 8'hEE; tick();
         beat(8'(8'h10 + i));
      end
      check("toggle_ref", 128'(ref_pixel), 128'h10);
      check("toggle_adj_msb", 128'(adj_pixel[127:120]), 128'h11);
      check("toggle_adj_lsb", 128'(adj_pixel[7:0]), 128'h20);
      consume = 1'b1; tick(); consume = 1'b0;

      // Abort after 5 beats, with a beat offered in the abort cycle
      pulse_start();
      for (int i = 0; i < 5; i++) beat(8'(8'h50 + i));
      start = 1'b1; in_valid = 1'b1; in_data = 8'h77; tick();
      start = 1'b0; in_valid = 1'b0;
      for (int i = 0; i <= NPTS; i++) beat(8'(8'hA0 + i));
      check("abort_win_valid", 128'(win_valid), 128'd1);
      check("abort_ref", 128'(ref_pixel), 128'hA0);
      check("abort_adj_msb", 128'(adj_pixel[127:120]), 128'hA1);
      check("abort_adj_lsb", 128'(adj_pixel[7:0]), 128'hB0);

      // Hold in FULL with live input traffic and a lone start
      held_adj = adj_pixel;
      held_ref = ref_pixel;
      for (int i = 0; i < 3; i++) beat(8'(8'hC0 + i));
      start = 1'b1; tick(); start = 1'b0;
      check("hold_win_valid", 128'(win_valid), 128'd1);
      check("hold_ref", 128'(ref_pixel), 128'(held_ref));
      check("hold_adj", 128'(adj_pixel), 128'(held_adj));

      consume = 1'b1; start = 1'b1; tick(); consume = 1'b0; start = 1'b0;
      check("restart_in_ready", 128'(in_ready), 128'd1);
      check("restart_win_valid", 128'(win_valid), 128'd0);

      // Threshold write mid-load, then async reset mid-load
      for (int i = 0; i < 4; i++) beat(8'(8'h30 + i));
      thres_we = 1'b1; thres_in = 8'h14; tick(); thres_we = 1'b0;
      check("thres_write", 128'(thres), 128'h14);
      check("thres_load_ready", 128'(in_ready), 128'd1);
      nReset = 1'b0;
      #1;
      check("arst_win_valid", 128'(win_valid), 128'd0);
      check("arst_thres", 128'(thres), 128'd30);
      check("arst_in_ready", 128'(in_ready), 128'd0);
      tick();
      nReset = 1'b1;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
